rdm_input_buffer: RTL and testbench

RDM_INPUT_BUFFER -- requirements
Module: rdm_input_buffer

---
 rtl/rdm_input_buffer.sv | 161 ++++++++++++++++
 tb/tb_rdm_input_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdm_input_buffer.sv
// Ping-pong LLR input buffer: packs LLR beats into LANES-wide lines, hands complete blocks to the rate-dematcher.
// Optional macro RDM_IBUF_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module rdm_input_buffer #(
    parameter int LLR_W = 6,
    parameter int LANES = 128,
    parameter int DEPTH = 128
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_llr_valid,
    input  logic [LLR_W-1:0]         i_llr_data,
    input  logic                     i_llr_last,
    output logic                     o_llr_ready,
    input  logic                     i_Input_Buffer_RDM_Data_Enable,
    input  logic [15:0]              i_Input_Buffer_Offset_Address,
    output logic [LANES*LLR_W-1:0]   o_Input_Buffer_RDM_Data_ALL,
    output logic                     o_RDM_Data_Request,
    input  logic                     i_rdm_done,
    output logic                     o_overflow
);

    localparam int LINE_W = LANES * LLR_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(2 * DEPTH) : 1;

    // Both banks share one array: bank b occupies entries [b*DEPTH, b*DEPTH+DEPTH-1].
    logic [LINE_W-1:0] mem [0:2*DEPTH-1];

    logic [LINE_W-1:0] line_buf_reg;
    logic [LINE_W-1:0] line_next;
    logic [LANE_W-1:0] lane_cnt_reg;
    logic [CNT_W-1:0]  line_cnt_reg;
    logic [CNT_W-1:0]  line_count_reg [2];
    logic [1:0]        full_reg;
    logic [1:0]        full_next;
    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic              overflow_reg;
    logic [LINE_W-1:0] ram_q_reg;
    logic              zero_reg;

    logic              accept;
    logic              lane_end;
    logic              block_end;
    logic              line_fits;
    logic              line_write;
    logic              rd_release;
    logic [RAM_AW-1:0] wr_addr;
    logic [RAM_AW-1:0] rd_addr;

    assign o_llr_ready        = !full_reg[wr_bank_reg];
    assign o_RDM_Data_Request = full_reg[rd_bank_reg];
    assign o_overflow         = overflow_reg;

    assign accept     = i_llr_valid && o_llr_ready;
    assign lane_end   = accept && ((lane_cnt_reg == LANE_W'(LANES - 1)) || i_llr_last);
    assign block_end  = accept && i_llr_last;
    assign line_fits  = line_cnt_reg < CNT_W'(DEPTH);
    assign line_write = lane_end && line_fits && i_rx_rstn;
    assign rd_release = i_rdm_done && full_reg[rd_bank_reg];

    assign wr_addr = RAM_AW'(int'(wr_bank_reg) * DEPTH + int'(line_cnt_reg));
    assign rd_addr = RAM_AW'(int'(rd_bank_reg) * DEPTH + int'(i_Input_Buffer_Offset_Address));

    // Lanes above the current one still hold zero because the line buffer is cleared after every write.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign line_next[gi*LLR_W +: LLR_W] = (lane_cnt_reg == LANE_W'(gi)) ?
                                                  i_llr_data : line_buf_reg[gi*LLR_W +: LLR_W];
        end
    endgenerate

    always_comb begin
        full_next = full_reg;
        if (block_end) begin
            full_next[wr_bank_reg] = 1'b1;
        end
        if (rd_release) begin
            full_next[rd_bank_reg] = 1'b0;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            line_buf_reg      <= '0;
            lane_cnt_reg      <= '0;
            line_cnt_reg      <= '0;
            line_count_reg[0] <= '0;
            line_count_reg[1] <= '0;
            full_reg          <= '0;
            wr_bank_reg       <= 1'b0;
            rd_bank_reg       <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (rd_release) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            if (accept) begin
                if (lane_end) begin
                    line_buf_reg <= '0;
                    lane_cnt_reg <= '0;
                    // Lines past DEPTH are dropped but the block still completes on last.
                    if (line_fits) begin
                        line_cnt_reg <= line_cnt_reg + 1'b1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end else begin
                    line_buf_reg <= line_next;
                    lane_cnt_reg <= lane_cnt_reg + 1'b1;
                end
            end
            if (block_end) begin
                line_cnt_reg                <= '0;
                line_count_reg[wr_bank_reg] <= line_fits ? line_cnt_reg + 1'b1 : line_cnt_reg;
                wr_bank_reg                 <= ~wr_bank_reg;
            end
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (line_write) begin
            mem[wr_addr] <= line_next;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_Input_Buffer_RDM_Data_Enable) begin
            ram_q_reg <= mem[rd_addr];
        end
    end

    // Out-of-range reads are masked after the RAM so the read port stays a plain block-RAM read.
    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            zero_reg <= 1'b1;
        end else if (i_Input_Buffer_RDM_Data_Enable) begin
            zero_reg <= int'(i_Input_Buffer_Offset_Address) >= int'(line_count_reg[rd_bank_reg]);
        end
    end

`ifdef RDM_IBUF_OUT_REG_EN
    logic [LINE_W-1:0] out_reg;

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            out_reg <= '0;
        end else begin
            out_reg <= zero_reg ? '0 : ram_q_reg;
        end
    end

    assign o_Input_Buffer_RDM_Data_ALL = out_reg;
`else
    assign o_Input_Buffer_RDM_Data_ALL = zero_reg ? '0 : ram_q_reg;
`endif

endmodule

// File: tb/tb_rdm_input_buffer.sv
// Bench for rdm_input_buffer: block-FIFO reference model checked every cycle plus directed literal checks.
module tb_rdm_input_buffer;

    localparam int LLR_W  = 6;
    localparam int LANES  = 128;
    localparam int DEPTH  = 4;
    localparam int LINE_W = LANES * LLR_W;
`ifdef RDM_IBUF_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              valid;
    logic [LLR_W-1:0]  data;
    logic              last;
    logic              en;
    logic [15:0]       addr;
    logic              done;
    logic              ready;
    logic              request;
    logic              overflow;
    logic [LINE_W-1:0] rd_data;

    int vectors = 0;
    int miscompares = 0;

    rdm_input_buffer #(.LLR_W(LLR_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_core_clk                     (clk),
        .i_rx_rstn                      (rstn),
        .i_llr_valid                    (valid),
        .i_llr_data                     (data),
        .i_llr_last                     (last),
        .o_llr_ready                    (ready),
        .i_Input_Buffer_RDM_Data_Enable (en),
        .i_Input_Buffer_Offset_Address  (addr),
        .o_Input_Buffer_RDM_Data_ALL    (rd_data),
        .o_RDM_Data_Request             (request),
        .i_rdm_done                     (done),
        .o_overflow                     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of at most two complete blocks, each a plain list of LLRs.
    logic [LLR_W-1:0]  part_q[$];
    logic [LLR_W-1:0]  blk0_q[$];
    logic [LLR_W-1:0]  blk1_q[$];
    int                nblk = 0;
    bit                m_ovf = 0;
    bit                started = 0;
    bit                m_acc;
    bit                m_rel;
    int                m_n;
    logic [LINE_W-1:0] exp1 = '0;
    logic [LINE_W-1:0] exp2 = '0;
    bit                known1 = 1;
    bit                known2 = 1;

    function automatic logic [LINE_W-1:0] model_line(input int a);
        logic [LINE_W-1:0] l = '0;
        for (int k = 0; k < LANES; k++) begin
            int idx = a * LANES + k;
            if (a < DEPTH && idx < blk0_q.size()) l[k*LLR_W +: LLR_W] = blk0_q[idx];
        end
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] fill(input int nl, input int v);
        logic [LINE_W-1:0] l = '0;
        for (int k = 0; k < nl; k++) l[k*LLR_W +: LLR_W] = LLR_W'(v);
        return l;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            part_q.delete(); blk0_q.delete(); blk1_q.delete();
            nblk = 0; m_ovf = 0;
            exp1 = '0; exp2 = '0; known1 = 1; known2 = 1;
            started = 1;
        end else if (started) begin
            m_acc = valid && (nblk < 2);
            m_rel = done && (nblk > 0);
            exp2 = exp1; known2 = known1;
            if (en) begin
                if (nblk > 0) begin
                    exp1 = model_line(int'(addr)); known1 = 1;
                end else begin
                    known1 = 0;
                end
            end
            if (m_rel) begin
                blk0_q = blk1_q; blk1_q.delete(); nblk--;
            end
            if (m_acc) begin
                m_n = part_q.size();
                if ((m_n / LANES) >= DEPTH && (last || (m_n % LANES) == LANES - 1)) m_ovf = 1;
                part_q.push_back(data);
                if (last) begin
                    if (nblk == 0) blk0_q = part_q; else blk1_q = part_q;
                    nblk++;
                    part_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [LINE_W-1:0] e;
            bit kn;
            e  = (LAT == 2) ? exp2 : exp1;
            kn = (LAT == 2) ? known2 : known1;
            chk("model_ready", ready, nblk < 2);
            chk("model_request", request, nblk > 0);
            chk("model_overflow", overflow, m_ovf);
            if (kn) chk("model_data", rd_data, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int d, input bit l);
        int w = 0;
        valid = 1; data = LLR_W'(d); last = l;
        while (!ready && w < 50) begin tick(); w++; end
        if (!ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: ready=%0b required 1", ready);
            valid = 0; last = 0;
            return;
        end
        tick();
        valid = 0; last = 0;
    endtask

    task automatic read_line(input int a);
        en = 1; addr = 16'(a);
        tick();
        en = 0;
        repeat (LAT - 1) tick();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        done = 1;
        tick();
        done = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] ln;
        rstn = 0; valid = 0; data = '0; last = 0; en = 0; addr = '0; done = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_request", request, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_data", rd_data, '0);
        rstn = 1;

        // 300 LLRs of 5: two full lines and 44 lanes of a third
        for (int i = 0; i < 300; i++) send_beat(5, i == 299);
        @(negedge clk);
        chk("t300_request", request, 1'b1);
        read_line(0); chk("t300_line0", rd_data, fill(128, 5));
        read_line(1); chk("t300_line1", rd_data, fill(128, 5));
        read_line(2); chk("t300_line2", rd_data, fill(44, 5));
        read_line(3); chk("t300_line3", rd_data, '0);

        // read latency: enable sampled at edge t, data visible after edge t+LAT-1
        en = 1; addr = 16'd0;
        tick();
        en = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("latency", rd_data, (i >= LAT) ? fill(128, 5) : '0);
        end
        pulse_done();
        @(negedge clk);
        chk("t300_request_fall", request, 1'b0);

        // two blocks fill both banks, third is back-pressured
        for (int i = 0; i < 128; i++) send_beat(i % 64, i == 127);
        for (int i = 0; i < 128; i++) send_beat(7, i == 127);
        @(negedge clk);
        chk("both_full_ready", ready, 1'b0);
        chk("both_full_request", request, 1'b1);
        valid = 1; data = 6'd1; last = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("third_block_held", ready, 1'b0);
        valid = 0;
        pulse_done();
        @(negedge clk);
        chk("freed_ready", ready, 1'b1);
        chk("freed_request", request, 1'b1);
        read_line(0); chk("block_b_line0", rd_data, fill(128, 7));
        pulse_done();

        // done coincident with the last beat of B
        for (int i = 0; i < 128; i++) send_beat(9, i == 127);
        for (int i = 0; i < 127; i++) send_beat(11, 1'b0);
        valid = 1; data = 6'd11; last = 1; done = 1;
        tick();
        valid = 0; last = 0; done = 0;
        @(negedge clk);
        chk("coincide_request", request, 1'b1);
        chk("coincide_ready", ready, 1'b1);
        read_line(0); chk("coincide_line0", rd_data, fill(128, 11));
        pulse_done();
        @(negedge clk);
        chk("coincide_request_fall", request, 1'b0);

        // overflow: 700 LLRs then last, only DEPTH lines kept
        for (int i = 0; i < 701; i++) send_beat(i % 32, i == 700);
        @(negedge clk);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_request", request, 1'b1);
        ln = '0;
        for (int k = 0; k < LANES; k++) ln[k*LLR_W +: LLR_W] = LLR_W'(k % 32);
        read_line(3); chk("ovf_line3", rd_data, ln);
        read_line(4); chk("ovf_line4", rd_data, '0);

        // reset mid-line, then a fresh block
        for (int i = 0; i < 50; i++) send_beat(3, 1'b0);
        rstn = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("midrst_request", request, 1'b0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_overflow", overflow, 1'b0);
        chk("midrst_data", rd_data, '0);
        rstn = 1;
        for (int i = 0; i < 128; i++) send_beat((i * 3) % 64, i == 127);
        ln = '0;
        for (int k = 0; k < LANES; k++) ln[k*LLR_W +: LLR_W] = LLR_W'((k * 3) % 64);
        @(negedge clk);
        chk("fresh_request", request, 1'b1);
        read_line(0); chk("fresh_line0", rd_data, ln);
        read_line(1); chk("fresh_line1", rd_data, '0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
